// File: rtl/data_memory_responder.sv
// rtl/data_memory_responder.sv - Fixed-latency line-wide DRAM responder for the L1 data cache
// Accepts one line read or write per request in IDLE and completes it with a one-cycle ack.
module data_memory_responder #(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 512,
  parameter int LATENCY    = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  input  logic                  mem_cs_i,
  input  logic                  mem_we_i,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  output logic                  mem_ack_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [CNT_W-1:0]      count;
  logic [IDX_W-1:0]      req_idx;
  logic                  req_we;
  logic [DATA_WIDTH-1:0] req_data;
  logic                  done;

  logic [DATA_WIDTH-1:0] memory [DEPTH];

  // Byte offset within the line and bits above the index do not select a line.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_addr_i[4:0], mem_addr_i[ADDR_WIDTH-1:5+IDX_W]};

  assign done = (state == BUSY) && (count == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (mem_cs_i) state_next = BUSY;
      BUSY:    if (done) state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_ack_o = (state == ACK);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count      <= '0;
      req_idx    <= '0;
      req_we     <= 1'b0;
      req_data   <= '0;
      mem_data_o <= '0;
    end else begin
      if (state == IDLE && mem_cs_i) begin
        req_idx  <= mem_addr_i[5 +: IDX_W];
        req_we   <= mem_we_i;
        req_data <= mem_data_i;
        count    <= '0;
      end else if (state == BUSY && !done) begin
        count <= count + CNT_W'(1);
      end
      if (done && !req_we) begin
        mem_data_o <= memory[req_idx];
      end
    end
  end

  // Array has no reset; a reset mid-request drops the write because state leaves BUSY.
  always_ff @(posedge clk) begin
    if (rst && done && req_we) begin
      memory[req_idx] <= req_data;
    end
  end

endmodule
